// File: rtl/dvga_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dvga_regbank: Wishbone B3 slave for DVGA control regs, palette, sprites    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dvga_regbank #(
  parameter int NREGS  = 8,
  parameter int NSPR   = 2,
  parameter int PAL_AW = 8,
  parameter int SPR_AW = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic [31:0]                wbs_dat_o,
  input  logic [3:0]                 wbs_sel_i,
  input  logic                       wbs_we_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  input  logic [2:0]                 wbs_cti_i,
  input  logic [1:0]                 wbs_bte_i,
  output logic [32*NREGS-1:0]        regs_o,
  output logic [NREGS-1:0]           reg_wr_o,
  input  logic [PAL_AW-1:0]          pal_adr_i,
  output logic [31:0]                pal_dat_o,
  input  logic [(SPR_AW+1)*NSPR-1:0] spr_adr_i,
  output logic [16*NSPR-1:0]         spr_dat_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RDWAIT = 3'd1,
    S_ACK    = 3'd2,
    S_BURST  = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [13:0]        w_cur, w_rd;
  logic               w_cur_map, w_rd_map, w_req, w_ack, w_err, w_wr_ok;
  logic [31:0]        r_dat, w_rd_val;
  logic [31:0]        r_regs [NREGS];
  logic [NREGS-1:0]   r_reg_wr, w_reg_hit;
  logic [31:0]        r_pal [2**PAL_AW];
  logic [31:0]        r_pal_dat;
  logic [NSPR-1:0][31:0] w_spr_rd;
  logic               w_unused;

  assign w_unused = ^{wbs_adr_i[31:16], wbs_adr_i[1:0]};

  function automatic logic f_mapped(input logic [13:0] w);
    logic [4:0] r;
    r = w[13:9];
    if (r == 5'd0) return 32'(w[5:0]) < NREGS;
    if (r == 5'd1) return (w[8:0] >> PAL_AW) == 9'd0;
    if (32'(r) >= 2 && 32'(r) < NSPR + 2) return (w[8:0] >> SPR_AW) == 9'd0;
    return 1'b0;
  endfunction

  // Bursts prefetch the next word so each beat's data is ready at its ack.
  assign w_cur     = wbs_adr_i[15:2];
  assign w_rd      = (r_state == S_ACK || r_state == S_BURST) ? w_cur + 14'd1 : w_cur;
  assign w_cur_map = f_mapped(w_cur);
  assign w_rd_map  = f_mapped(w_rd);
  assign w_req     = wbs_cyc_i & wbs_stb_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ack  = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (!w_cur_map)                          w_next = S_ERR;
          else if (!wbs_we_i && w_cur[13:9] != 5'd0) w_next = S_RDWAIT;
          else                                     w_next = S_ACK;
        end
      end
      S_RDWAIT: w_next = w_req ? S_ACK : S_IDLE;
      S_ACK: begin
        w_ack  = 1'b1;
        w_next = (w_req && wbs_cti_i == 3'b010 && wbs_bte_i == 2'b00) ? S_BURST : S_IDLE;
      end
      S_BURST: begin
        if (!w_req)          w_next = S_IDLE;
        else if (!w_cur_map) w_next = S_ERR;
        else begin
          w_ack  = 1'b1;
          w_next = (wbs_cti_i == 3'b010) ? S_BURST : S_IDLE;
        end
      end
      S_ERR: begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_wr_ok   = w_ack & wbs_we_i & w_cur_map;
  assign wbs_ack_o = w_ack;
  assign wbs_err_o = w_err;
  assign wbs_dat_o = w_ack ? r_dat : 32'd0;

  always_comb begin
    w_reg_hit = '0;
    for (int k = 0; k < NREGS; k++)
      w_reg_hit[k] = w_wr_ok && (w_cur[13:9] == 5'd0) && (w_cur[5:0] == 6'(k));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
      r_reg_wr <= '0;
    end else begin
      r_reg_wr <= w_reg_hit;
      for (int k = 0; k < NREGS; k++)
        for (int b = 0; b < 4; b++)
          if (w_reg_hit[k] && wbs_sel_i[b]) r_regs[k][8*b +: 8] <= wbs_dat_i[8*b +: 8];
    end
  end

  assign reg_wr_o = r_reg_wr;

  generate
    for (genvar k = 0; k < NREGS; k++) begin : g_regs
      assign regs_o[32*k +: 32] = r_regs[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr_ok && w_cur[13:9] == 5'd1)
      for (int b = 0; b < 4; b++)
        if (wbs_sel_i[b]) r_pal[w_cur[PAL_AW-1:0]][8*b +: 8] <= wbs_dat_i[8*b +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pal_dat <= '0;
    else     r_pal_dat <= r_pal[pal_adr_i];
  end

  assign pal_dat_o = r_pal_dat;

  generate
    for (genvar s = 0; s < NSPR; s++) begin : g_spr
      logic [31:0]       r_mem [2**SPR_AW];
      logic [31:0]       r_word;
      logic              r_lsb;
      logic [SPR_AW:0]   w_padr;

      assign w_padr = spr_adr_i[(SPR_AW+1)*s +: SPR_AW+1];

      always_ff @(posedge clk) begin
        if (w_wr_ok && 32'(w_cur[13:9]) == s + 2)
          for (int b = 0; b < 4; b++)
            if (wbs_sel_i[b]) r_mem[w_cur[SPR_AW-1:0]][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_word <= '0;
          r_lsb  <= 1'b0;
        end else begin
          r_word <= r_mem[w_padr[SPR_AW:1]];
          r_lsb  <= w_padr[0];
        end
      end

      assign w_spr_rd[s]         = r_mem[w_rd[SPR_AW-1:0]];
      assign spr_dat_o[16*s +: 16] = r_lsb ? r_word[15:0] : r_word[31:16];
    end
  endgenerate

  always_comb begin
    w_rd_val = '0;
    if (w_rd_map) begin
      if (w_rd[13:9] == 5'd0) begin
        for (int k = 0; k < NREGS; k++)
          if (w_rd[5:0] == 6'(k)) w_rd_val = r_regs[k];
      end else if (w_rd[13:9] == 5'd1) begin
        w_rd_val = r_pal[w_rd[PAL_AW-1:0]];
      end else begin
        for (int s = 0; s < NSPR; s++)
          if (32'(w_rd[13:9]) == s + 2) w_rd_val = w_spr_rd[s];
      end
    end
  end

  // Captured before any same-edge write, so reads see pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dat <= '0;
    else     r_dat <= w_rd_val;
  end

endmodule
`default_nettype wire
